// File: rtl/load_store_unit_if.sv
// Bundles the CPU request/response handshake and the word-memory port of the
// load/store unit. The slave side is the unit itself; the master side is the
// surrounding CPU and memory.
`timescale 1ns/1ps
interface load_store_unit_if #(
  parameter int MEM_AW = 10,
  parameter int DW     = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [DW-1:0]     req_wdata;
  logic              resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_di;
  logic [DW-1:0]     mem_do;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_do,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_di
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_do,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into accesses on a
// word-wide async-read, sync-write memory. Sub-word stores use a
// read-modify-write pass; loads extract and extend the addressed lane.
// Misaligned or illegal-size requests are answered with an error and never
// reach the memory.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int MEM_AW = 10,
  parameter int DW     = 32
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RMW   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [MEM_AW+1:0] addr_q;
  logic [DW-1:0]     wdata_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [DW-1:0]     wbuf_q;
  logic [DW-1:0]     rdata_q;
  logic              accept;

  // True when the request cannot be served: wrong alignment or size 11.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed byte/half out of a memory word and sign/zero extend it.
  function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] word,
                                                input logic [1:0]    off,
                                                input logic [1:0]    size,
                                                input logic          sgn);
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [DW-1:0] res;
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{(DW-8){sgn & lane_b[7]}}, lane_b};
      2'b01:   res = {{(DW-16){sgn & lane_h[15]}}, lane_h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the low byte/half of the store data onto the addressed lane,
  // leaving the remaining lanes of the old word intact.
  function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] old,
                                                input logic [DW-1:0] wd,
                                                input logic [1:0]    off,
                                                input logic [1:0]    size);
    logic [DW-1:0] mask;
    logic [DW-1:0] data;
    if (size == 2'b00) begin
      mask = {{(DW-8){1'b0}}, 8'hFF} << {off, 3'b000};
      data = {{(DW-8){1'b0}}, wd[7:0]} << {off, 3'b000};
    end else begin
      mask = {{(DW-16){1'b0}}, 16'hFFFF} << {off[1], 4'b0000};
      data = {{(DW-16){1'b0}}, wd[15:0]} << {off[1], 4'b0000};
    end
    return (old & ~mask) | data;
  endfunction

  assign accept = (state_q == IDLE) && bus.req_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; the request type picks the path out of IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) state_d = ERR;
          else if (!bus.req_we)                               state_d = LOAD;
          else if (bus.req_size == 2'b10)                     state_d = WRITE;
          else                                                state_d = RMW;
        end
      end
      LOAD:    state_d = DONE;
      RMW:     state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and memory strobes; strobes are forced off while reset is high
  // so an aborted store can never write.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE) || (state_q == ERR);
    bus.resp_err   = (state_q == ERR);
    bus.mem_en     = !reset && ((state_q == LOAD) || (state_q == RMW) ||
                                (state_q == WRITE));
    bus.mem_we     = !reset && (state_q == WRITE);
  end

  // Request capture, load result and RMW write buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wbuf_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= bus.req_addr[MEM_AW+1:0];
        wdata_q  <= bus.req_wdata;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
      end
      if (state_q == LOAD)
        rdata_q <= load_extend(bus.mem_do, addr_q[1:0], size_q, signed_q);
      if (state_q == RMW)
        wbuf_q <= store_merge(bus.mem_do, wdata_q, addr_q[1:0], size_q);
    end
  end

  assign bus.mem_addr   = addr_q[MEM_AW+1:2];
  assign bus.mem_di     = (size_q == 2'b10) ? wdata_q : wbuf_q;
  assign bus.resp_rdata = rdata_q;

endmodule
